// File: rtl/piece_sequencer.sv
// Tetromino scheduler: 7-bag randomizer feeding a preview queue, req/ack spawn port.
// Define PIECE_SEQUENCER_HOLD_EN to enable the one-slot hold swap.
module piece_sequencer #(
  parameter int unsigned PREVIEW_DEPTH = 3,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       seed_load,
  input  logic [15:0]                seed,
  input  logic                       spawn_req,
  output logic                       spawn_ack,
  output logic [2:0]                 spawn_id,
  output logic [3*PREVIEW_DEPTH-1:0] preview_id,
  output logic                       ready,
  input  logic                       hold_req,
  input  logic [2:0]                 hold_in_id,
  output logic                       hold_valid,
  output logic [2:0]                 hold_id
);

  localparam int unsigned IDW    = 3;
  localparam int unsigned NIDS   = 7;
  localparam int unsigned QDEPTH = PREVIEW_DEPTH + 1;
  localparam int unsigned CW     = $clog2(QDEPTH + 1);
  localparam int unsigned RW     = 3;
  localparam logic [RW-1:0] RETRY_MAX = RW'(7);

  typedef enum logic {S_FILL, S_READY} state_t;

  state_t                     state, state_d;
  logic [15:0]                lfsr, lfsr_d;
  logic [QDEPTH-1:0][IDW-1:0] q, q_d;
  logic [CW-1:0]              cnt, cnt_d;
  logic [NIDS-1:0]            bag, bag_d, bag_set;
  logic [RW-1:0]              retry, retry_d;
  logic                       spawn_ack_d, hold_valid_d;
  logic [IDW-1:0]             spawn_id_d, hold_id_d;
  logic [IDW-1:0]             cand, lowest, pick;
  logic [NIDS:0]              used;
  logic                       accept, pop;

`ifdef PIECE_SEQUENCER_HOLD_EN
  logic lock, lock_d;

  // Hold lock: set by any hold action, cleared only by a normal spawn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lock <= 1'b0;
    else        lock <= lock_d;
  end
`else
  logic unused_hold;
  assign unused_hold = ^{hold_req, hold_in_id};
`endif

  // Lowest id not yet issued in the current bag (fallback after retries run out).
  always_comb begin
    lowest = '0;
    for (int i = int'(NIDS) - 1; i >= 0; i--)
      if (!bag[i]) lowest = IDW'(i);
  end

  always_comb begin
    state_d      = state;
    lfsr_d       = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    q_d          = q;
    cnt_d        = cnt;
    bag_d        = bag;
    bag_set      = bag;
    retry_d      = retry;
    spawn_ack_d  = 1'b0;
    spawn_id_d   = spawn_id;
    hold_valid_d = hold_valid;
    hold_id_d    = hold_id;
`ifdef PIECE_SEQUENCER_HOLD_EN
    lock_d       = lock;
`endif
    cand         = lfsr[2:0];
    used         = {1'b1, bag};
    accept       = 1'b0;
    pick         = cand;
    pop          = 1'b0;

    if (seed_load) begin
      lfsr_d  = (seed == 16'h0000) ? LFSR_SEED : seed;
      q_d     = '0;
      cnt_d   = '0;
      bag_d   = '0;
      retry_d = '0;
      state_d = S_FILL;
    end else if (state == S_FILL) begin
      // Id 7 maps to used[7]=1, so it is rejected like an already-issued id.
      if (!used[cand]) begin
        accept = 1'b1;
      end else if (retry == RETRY_MAX) begin
        accept = 1'b1;
        pick   = lowest;
      end else begin
        retry_d = retry + RW'(1);
      end
      if (accept) begin
        for (int i = 0; i < int'(QDEPTH); i++)
          if (CW'(i) == cnt) q_d[i] = pick;
        bag_set = bag | (NIDS'(1) << pick);
        bag_d   = (bag_set == {NIDS{1'b1}}) ? '0 : bag_set;
        retry_d = '0;
        cnt_d   = cnt + CW'(1);
        if (cnt_d == CW'(QDEPTH)) state_d = S_READY;
      end
    end else if (spawn_req) begin
      pop = 1'b1;
`ifdef PIECE_SEQUENCER_HOLD_EN
      lock_d = 1'b0;
    end else if (hold_req) begin
      spawn_ack_d = 1'b1;
      if (!lock) begin
        lock_d    = 1'b1;
        hold_id_d = hold_in_id;
        if (!hold_valid) begin
          hold_valid_d = 1'b1;
          pop          = 1'b1;
        end else begin
          spawn_id_d = hold_id;
        end
      end
`endif
    end

    // Issue the queue head and shift the remaining entries toward slot 0.
    if (pop) begin
      spawn_ack_d = 1'b1;
      spawn_id_d  = q[0];
      q_d         = {IDW'(0), q[QDEPTH-1:1]};
      cnt_d       = cnt - CW'(1);
      state_d     = S_FILL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_FILL;
      lfsr       <= LFSR_SEED;
      q          <= '0;
      cnt        <= '0;
      bag        <= '0;
      retry      <= '0;
      spawn_ack  <= 1'b0;
      spawn_id   <= '0;
      preview_id <= '0;
      ready      <= 1'b0;
      hold_valid <= 1'b0;
      hold_id    <= '0;
    end else begin
      state      <= state_d;
      lfsr       <= lfsr_d;
      q          <= q_d;
      cnt        <= cnt_d;
      bag        <= bag_d;
      retry      <= retry_d;
      spawn_ack  <= spawn_ack_d;
      spawn_id   <= spawn_id_d;
      preview_id <= q[QDEPTH-1:1];
      ready      <= (state_d == S_READY);
      hold_valid <= hold_valid_d;
      hold_id    <= hold_id_d;
    end
  end

endmodule

// File: tb/tb_piece_sequencer.sv
// Self-checking bench for piece_sequencer: queue/bag reference model plus directed scenarios.
// Hold scenarios run when PIECE_SEQUENCER_HOLD_EN is defined.
module tb_piece_sequencer;

  localparam int unsigned PD    = 3;
  localparam int unsigned QD    = PD + 1;
  localparam logic [15:0] SEED0 = 16'hACE1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          seed_load = 1'b0;
  logic [15:0]   seed = '0;
  logic          spawn_req = 1'b0;
  logic          spawn_ack;
  logic [2:0]    spawn_id;
  logic [3*PD-1:0] preview_id;
  logic          ready;
  logic          hold_req = 1'b0;
  logic [2:0]    hold_in_id = '0;
  logic          hold_valid;
  logic [2:0]    hold_id;

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  piece_sequencer #(.PREVIEW_DEPTH(PD), .LFSR_SEED(SEED0)) dut (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed),
    .spawn_req(spawn_req), .spawn_ack(spawn_ack), .spawn_id(spawn_id),
    .preview_id(preview_id), .ready(ready), .hold_req(hold_req),
    .hold_in_id(hold_in_id), .hold_valid(hold_valid), .hold_id(hold_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: preview queue as an SV queue, bag as a set of issued ids.
  int          mq[$];
  logic [6:0]  mbag = '0;
  int          mretry = 0;
  logic [15:0] mlfsr = SEED0;
  bit          mrdy = 1'b0;
  bit          mack = 1'b0;
  bit          mhv = 1'b0;
  logic [2:0]  mspawn = '0;
  logic [2:0]  mhid = '0;
  logic [3*PD-1:0] mprev = '0;
`ifdef PIECE_SEQUENCER_HOLD_EN
  bit          mlock = 1'b0;
`endif

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    logic fb;
    fb = v[15] ^ v[13] ^ v[12] ^ v[10];
    return 16'((32'(v) << 1) | 32'(fb));
  endfunction

  function automatic logic [3*PD-1:0] model_preview();
    logic [3*PD-1:0] p;
    p = '0;
    for (int k = 0; k < int'(PD); k++)
      if (k + 1 < mq.size()) p[3*k +: 3] = 3'(mq[k+1]);
    return p;
  endfunction

  task automatic model_reset();
    mq.delete();
    mbag = '0; mretry = 0; mlfsr = SEED0; mrdy = 1'b0; mack = 1'b0;
    mhv = 1'b0; mspawn = '0; mhid = '0; mprev = '0;
`ifdef PIECE_SEQUENCER_HOLD_EN
    mlock = 1'b0;
`endif
  endtask

  task automatic model_step();
    int c;
    int pick;
    logic [15:0] cur;
    cur = mlfsr;
    mprev = model_preview();
    mack = 1'b0;
    mlfsr = lfsr_next(cur);
    if (seed_load) begin
      mlfsr = (seed == 16'h0) ? SEED0 : seed;
      mq.delete();
      mbag = '0; mretry = 0; mrdy = 1'b0;
    end else if (!mrdy) begin
      c = int'(cur[2:0]);
      pick = -1;
      if (c < 7 && !mbag[c]) pick = c;
      else if (mretry == 7) begin
        for (int i = 6; i >= 0; i--) if (!mbag[i]) pick = i;
      end else mretry++;
      if (pick >= 0) begin
        mq.push_back(pick);
        mbag[pick] = 1'b1;
        if (mbag == 7'h7F) mbag = '0;
        mretry = 0;
        if (mq.size() == QD) mrdy = 1'b1;
      end
    end else if (spawn_req) begin
      mspawn = 3'(mq.pop_front());
      mack = 1'b1;
      mrdy = 1'b0;
`ifdef PIECE_SEQUENCER_HOLD_EN
      mlock = 1'b0;
    end else if (hold_req) begin
      mack = 1'b1;
      if (!mlock) begin
        mlock = 1'b1;
        if (!mhv) begin
          mhv = 1'b1; mhid = hold_in_id;
          mspawn = 3'(mq.pop_front());
          mrdy = 1'b0;
        end else begin
          mspawn = mhid; mhid = hold_in_id;
        end
      end
`endif
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (mon_en) begin
      check("ack",        32'(spawn_ack),  32'(mack));
      check("spawn_id",   32'(spawn_id),   32'(mspawn));
      check("preview",    32'(preview_id), 32'(mprev));
      check("ready",      32'(ready),      32'(mrdy));
      check("hold_valid", 32'(hold_valid), 32'(mhv));
      check("hold_id",    32'(hold_id),    32'(mhid));
    end
  end

  function automatic bit distinct4(input logic [2:0] head, input logic [3*PD-1:0] prev);
    logic [7:0] m;
    m = '0;
    m[head] = 1'b1;
    for (int k = 0; k < int'(PD); k++) m[prev[3*k +: 3]] = 1'b1;
    return (m[7] == 1'b0) && ($countones(m) == int'(QD));
  endfunction

  function automatic logic [7:0] perm_mask(input logic [2:0] s[$], input int start);
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < 7; i++) m[s[start+i]] = 1'b1;
    return m;
  endfunction

  task automatic request(input bit use_hold, input logic [2:0] hin,
                         output logic [2:0] got_id, output bit got_ack);
    got_ack = 1'b0;
    got_id = '0;
    spawn_req = !use_hold;
    hold_req = use_hold;
    hold_in_id = hin;
    for (int i = 0; i < 64 && !got_ack; i++) begin
      @(negedge clk);
      if (spawn_ack) begin got_ack = 1'b1; got_id = spawn_id; end
    end
    spawn_req = 1'b0;
    hold_req = 1'b0;
  endtask

  task automatic spawn_one(output logic [2:0] id);
    bit ack;
    request(1'b0, 3'd0, id, ack);
    check("spawn_acked", 32'(ack), 32'd1);
  endtask

  task automatic load_seed(input logic [15:0] v);
    seed = v;
    seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
  endtask

  // Called with rst_n already low: checks reset values, releases, waits for ready.
  task automatic reset_release();
    int lat;
    mon_en = 1'b1;
    check("rst_ack",        32'(spawn_ack),  32'd0);
    check("rst_ready",      32'(ready),      32'd0);
    check("rst_preview",    32'(preview_id), 32'd0);
    check("rst_spawn_id",   32'(spawn_id),   32'd0);
    check("rst_hold_valid", 32'(hold_valid), 32'd0);
    check("rst_hold_id",    32'(hold_id),    32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
    while (!ready && lat < 40) begin @(negedge clk); lat++; end
    check("ready_latency", 32'(lat >= 4 && lat <= 32), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    reset_release();
  endtask

  initial begin : main
    logic [2:0] id, first_id, head0;
    logic [2:0] ids[$];
    logic [2:0] seq_a[$];
    logic [2:0] seq_b[$];
    bit ack;
    int rise, ack_at, acks, r;

    // Power-up: first spawn also checks the full queue contents.
    do_reset();
    for (int n = 0; n < 14; n++) begin
      spawn_one(id);
      if (n == 0) check("distinct4", 32'(distinct4(id, preview_id)), 32'd1);
      ids.push_back(id);
    end
    head0 = ids[0];
    check("perm_first7",  32'(perm_mask(ids, 0)), 32'h7F);
    check("perm_second7", 32'(perm_mask(ids, 7)), 32'h7F);

    // Zero seed substitutes LFSR_SEED.
    load_seed(16'h0000);
    for (int n = 0; n < 7; n++) begin spawn_one(id); seq_a.push_back(id); end
    load_seed(SEED0);
    for (int n = 0; n < 7; n++) begin spawn_one(id); seq_b.push_back(id); end
    check("perm_seed0", 32'(perm_mask(seq_a, 0)), 32'h7F);
    for (int n = 0; n < 7; n++) check("seed0_vs_ace1", 32'(seq_a[n]), 32'(seq_b[n]));

    // Request raised during refill is served exactly once, right after ready.
    load_seed(16'h1234);
    check("fill_not_ready", 32'(ready), 32'd0);
    spawn_req = 1'b1;
    rise = -1; ack_at = -1; acks = 0;
    for (int cyc = 0; cyc < 48; cyc++) begin
      @(negedge clk);
      if (spawn_ack) begin acks++; if (ack_at < 0) ack_at = cyc; spawn_req = 1'b0; end
      if (ready && rise < 0) rise = cyc;
    end
    spawn_req = 1'b0;
    check("fill_ack_count", 32'(acks), 32'd1);
    check("fill_ack_timing", 32'(ack_at), 32'(rise + 1));

`ifdef PIECE_SEQUENCER_HOLD_EN
    do_reset();
    request(1'b1, 3'd3, id, ack);
    check("hold1_ack", 32'(ack), 32'd1);
    check("hold1_valid", 32'(hold_valid), 32'd1);
    check("hold1_id", 32'(hold_id), 32'd3);
    first_id = id;
    request(1'b1, 3'd5, id, ack);
    check("hold2_ack", 32'(ack), 32'd1);
    check("hold2_locked_spawn", 32'(id), 32'(first_id));
    check("hold2_locked_hold", 32'(hold_id), 32'd3);
    spawn_one(id);
    request(1'b1, 3'd5, id, ack);
    check("hold3_ack", 32'(ack), 32'd1);
    check("hold3_swap_spawn", 32'(id), 32'd3);
    check("hold3_swap_hold", 32'(hold_id), 32'd5);
`else
    first_id = '0;
    request(1'b1, 3'd3, id, ack);
    check("hold_ignored_ack", 32'(ack), 32'd0);
    check("hold_ignored_valid", 32'(hold_valid), 32'(first_id));
`endif

    // Randomized traffic: idle gaps, reseeds, reseed under a pending request, holds.
    for (int it = 0; it < 200; it++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        load_seed(16'($urandom));
      end else if (r == 1) begin
        spawn_req = 1'b1;
        load_seed(16'($urandom));
        spawn_one(id);
`ifdef PIECE_SEQUENCER_HOLD_EN
      end else if (r <= 3) begin
        request(1'b1, 3'($urandom_range(0, 6)), id, ack);
        check("rand_hold_ack", 32'(ack), 32'd1);
`endif
      end else begin
        spawn_one(id);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Asynchronous reset in the ack cycle, then refill from LFSR_SEED.
    load_seed(16'h5A5A);
    request(1'b0, 3'd0, id, ack);
    check("prereset_ack", 32'(ack), 32'd1);
    #2 check("prereset_ack_high", 32'(spawn_ack), 32'd1);
    rst_n = 1'b0;
    #1;
    reset_release();
    spawn_one(id);
    check("restart_first", 32'(id), 32'(head0));

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got no completion, expected finish before %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/piece_sequencer.md
Name: piece_sequencer

Overview:
- Schedules which tetromino spawns next and drives the 3-bit shape_id consumed by the shape display decoder and the game FSM.
- Keeps a preview queue filled from a 7-bag randomizer: every group of 7 issued pieces is a permutation of ids 0..6 (O, I, T, L, J, S, Z).
- Serves spawn requests from the game FSM over a req/ack handshake and optionally provides a one-slot hold swap.

Parameters:
- PREVIEW_DEPTH, 3: number of preview slots exported to the display, legal range 1..4; total queue depth is PREVIEW_DEPTH+1.
- LFSR_SEED, 16'hACE1: LFSR reset value, and the substitute used whenever a zero seed is loaded.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- seed_load  in  1  pulse: load seed, flush queue and bag, refill.
- seed  in  16  seed value used with seed_load.
- spawn_req  in  1  level; held by the game FSM until spawn_ack.
- spawn_ack  out  1  one-cycle pulse; spawn_id is valid in this cycle.
- spawn_id  out  3  id of the piece to spawn; holds its value between acks.
- preview_id  out  3*PREVIEW_DEPTH  upcoming ids; slot k at bits [3k+2:3k], slot 0 is the next piece after spawn_id.
- ready  out  1  queue full and idle.
- hold_req  in  1  level; held until spawn_ack.
- hold_in_id  in  3  id of the currently active piece being held.
- hold_valid  out  1  hold slot occupied.
- hold_id  out  3  held piece id.

Behaviour:
- Reset (async, rst_n=0):
  - spawn_ack=0, spawn_id=0, preview_id=0, ready=0, hold_valid=0, hold_id=0.
  - Queue empty, fill count 0, bag mask 7'h00, hold lock 0, lfsr=LFSR_SEED, state S_FILL.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Free-running: shifts every cycle except the cycle it is loaded.
- States: S_FILL, S_READY. ready=1 only in S_READY.
- S_FILL, each cycle:
  - Candidate c = lfsr[2:0].
  - Accept if c!=7 and bag_mask[c]==0; otherwise increment the retry counter.
  - When the retry counter reaches 7, accept the lowest-index unused id instead, so insertion is guaranteed within at most 8 cycles.
  - On accept: append the id at the queue tail, set bag_mask[id], reset the retry counter.
  - If the mask becomes 7'h7F, clear it to 7'h00 in the same cycle.
  - When fill count reaches PREVIEW_DEPTH+1, go to S_READY.
- Queue mapping: queue head = q[0]; preview slot k = q[k+1]. preview_id updates in the cycle after each queue change.
- S_READY with spawn_req=1:
  - Next cycle: spawn_id<=q[0], spawn_ack=1, queue shifts down by one, fill count decrements, hold lock clears.
  - State goes to S_FILL.
- spawn_req or hold_req while in S_FILL: not serviced and not dropped. The request is served in the first cycle after S_READY is reached, since the requester holds it.
- The requester must drop spawn_req in the ack cycle. A request seen high in the cycle after ack is treated as a new request.
- spawn_req and hold_req both high: spawn wins; the hold is ignored for that request.
- seed_load:
  - Highest priority, accepted in any state.
  - lfsr<=(seed==0 ? LFSR_SEED : seed); queue, fill count, bag mask and retry counter cleared; state S_FILL.
  - Hold slot preserved; spawn_id unchanged.
  - An in-progress request waits for the refill.
- Width rule: spawn_id, preview_id and hold_id never carry value 7 after their first update.

Optional Feature:
- Macro PIECE_SEQUENCER_HOLD_EN. Ports exist in both builds.
- With the macro, hold_req in S_READY with hold lock=0:
  - Hold empty: hold_id<=hold_in_id, hold_valid<=1, then the same action as a normal spawn (queue shift, refill).
  - Hold occupied: spawn_id<=hold_id, hold_id<=hold_in_id, spawn_ack pulse, no queue shift, stay in S_READY.
  - In both cases hold lock is set. It clears only on a normal spawn.
  - hold_req while lock=1: answered with spawn_ack carrying spawn_id unchanged; no state change.
- Without the macro: hold_req and hold_in_id ignored; hold_valid=0 and hold_id=0 constantly; hold lock logic absent.

Test Plan:
- Release reset with default parameters -> ready rises within 4..32 cycles; the 3 preview slots plus the head are 4 distinct ids in 0..6.
- 14 back-to-back spawns, one per ack -> each group of 7 consecutive spawn_id values is a permutation of {0..6}; no id is ever 7.
- seed_load with seed=16'h0000, then again with 16'hACE1, each followed by 7 spawns -> the two spawn sequences are identical.
- spawn_req raised during S_FILL and held -> exactly one spawn_ack, 1 cycle after ready rises; no ack while in S_FILL.
- HOLD_EN build: hold_req with hold_in_id=3 and hold empty -> hold_valid=1, hold_id=3, queue head spawned; a second hold_req with id=5 before any spawn -> ack with spawn_id unchanged, hold_id stays 3; after a normal spawn, hold_req with id=5 -> spawn_id=3, hold_id=5.
- Assert rst_n low in the ack cycle -> spawn_ack, ready and preview_id drop to 0 immediately (asynchronously); refill restarts from LFSR_SEED.
